// File: rtl/banked_register_file_if.sv
// Port bundle for banked_register_file: read/write ports, bank select and copy control.
// The master side is the pipeline/control unit; the slave side is the register file.
interface banked_register_file_if #(
  parameter int unsigned DATA_WIDTH        = 8,
  parameter int unsigned REGISTER_ID_WIDTH = 2,
  parameter int unsigned BANK_ID_WIDTH     = 1
);
  logic [REGISTER_ID_WIDTH-1:0] reg1;
  logic [REGISTER_ID_WIDTH-1:0] reg2;
  logic [DATA_WIDTH-1:0]        read1;
  logic [DATA_WIDTH-1:0]        read2;
  logic [REGISTER_ID_WIDTH-1:0] w_reg;
  logic [DATA_WIDTH-1:0]        w_data;
  logic                         w_en;
  logic [BANK_ID_WIDTH-1:0]     bank_sel;
  logic                         bank_sel_en;
  logic                         copy_start;
  logic [BANK_ID_WIDTH-1:0]     copy_src;
  logic [BANK_ID_WIDTH-1:0]     copy_dst;
  logic [BANK_ID_WIDTH-1:0]     active_bank;
  logic                         busy;
  logic                         copy_done;

  modport master (
    output reg1, reg2, w_reg, w_data, w_en, bank_sel, bank_sel_en,
           copy_start, copy_src, copy_dst,
    input  read1, read2, active_bank, busy, copy_done
  );

  modport slave (
    input  reg1, reg2, w_reg, w_data, w_en, bank_sel, bank_sel_en,
           copy_start, copy_src, copy_dst,
    output read1, read2, active_bank, busy, copy_done
  );
endinterface

// File: rtl/banked_register_file.sv
// Banked CPU register file: two combinational read ports and one write port on the active
// bank, optional write bypass / hardwired zero register, and a bank-copy sequencer.
module banked_register_file #(
  parameter int unsigned DATA_WIDTH        = 8,
  parameter int unsigned REGISTER_ID_WIDTH = 2,
  parameter int unsigned BANK_ID_WIDTH     = 1,
  parameter bit          BYPASS            = 1'b1,
  parameter bit          ZERO_REG          = 1'b0
) (
  input logic                   clk,
  input logic                   rst_n,
  banked_register_file_if.slave bus
);
  localparam int unsigned DEPTH     = 2 ** REGISTER_ID_WIDTH;
  localparam int unsigned NUM_BANKS = 2 ** BANK_ID_WIDTH;

  typedef logic [REGISTER_ID_WIDTH-1:0] reg_id_t;
  typedef logic [BANK_ID_WIDTH-1:0]     bank_id_t;
  typedef logic [DATA_WIDTH-1:0]        data_t;

  typedef enum logic [1:0] {StIdle, StCopy, StDone} copy_state_e;

  data_t       mem_q [NUM_BANKS][DEPTH];
  bank_id_t    active_bank_q;
  bank_id_t    src_q;
  bank_id_t    dst_q;
  reg_id_t     idx_q;
  copy_state_e state_q;
  logic        busy_q;
  logic        done_q;

  logic  copy_we;
  logic  user_we;
  data_t read1;
  data_t read2;

  // Register 0 is never written when it is hardwired to zero, whether by user or copy.
  assign copy_we = busy_q && !(ZERO_REG && (idx_q == '0));
  assign user_we = bus.w_en && !(ZERO_REG && (bus.w_reg == '0));

  // User write is issued after the copy write so it wins on a same-register collision;
  // the copy source is read pre-edge, so a same-cycle write to src[idx] is not copied.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
        for (int unsigned d = 0; d < DEPTH; d++) begin
          mem_q[b][d] <= '0;
        end
      end
    end else begin
      if (copy_we) mem_q[dst_q][idx_q] <= mem_q[src_q][idx_q];
      if (user_we) mem_q[active_bank_q][bus.w_reg] <= bus.w_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      active_bank_q <= '0;
      src_q         <= '0;
      dst_q         <= '0;
      idx_q         <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      if (bus.bank_sel_en && !busy_q) active_bank_q <= bus.bank_sel;
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (bus.copy_start) begin
            src_q   <= bus.copy_src;
            dst_q   <= bus.copy_dst;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StCopy;
          end
        end
        StCopy: begin
          if (idx_q == reg_id_t'(DEPTH - 1)) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    read1 = mem_q[active_bank_q][bus.reg1];
    if (BYPASS && bus.w_en && (bus.w_reg == bus.reg1)) read1 = bus.w_data;
    if (ZERO_REG && (bus.reg1 == '0)) read1 = '0;
  end

  always_comb begin
    read2 = mem_q[active_bank_q][bus.reg2];
    if (BYPASS && bus.w_en && (bus.w_reg == bus.reg2)) read2 = bus.w_data;
    if (ZERO_REG && (bus.reg2 == '0)) read2 = '0;
  end

  assign bus.read1       = read1;
  assign bus.read2       = read2;
  assign bus.active_bank = active_bank_q;
  assign bus.busy        = busy_q;
  assign bus.copy_done   = done_q;
endmodule

// File: tb/tb_banked_register_file.sv
// Directed bench for banked_register_file: three instances (bypass, no bypass, zero reg)
// share one stimulus stream; expected values are hand-computed constants.
module tb_banked_register_file;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] reg1 = '0, reg2 = '0, w_reg = '0;
  logic [7:0] w_data = '0;
  logic       w_en = 1'b0, bank_sel = 1'b0, bank_sel_en = 1'b0;
  logic       copy_start = 1'b0, copy_src = 1'b0, copy_dst = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  banked_register_file_if #(.DATA_WIDTH(8), .REGISTER_ID_WIDTH(2), .BANK_ID_WIDTH(1)) ifa ();
  banked_register_file_if #(.DATA_WIDTH(8), .REGISTER_ID_WIDTH(2), .BANK_ID_WIDTH(1)) ifb ();
  banked_register_file_if #(.DATA_WIDTH(8), .REGISTER_ID_WIDTH(2), .BANK_ID_WIDTH(1)) ifc ();

  assign ifa.reg1 = reg1;         assign ifb.reg1 = reg1;         assign ifc.reg1 = reg1;
  assign ifa.reg2 = reg2;         assign ifb.reg2 = reg2;         assign ifc.reg2 = reg2;
  assign ifa.w_reg = w_reg;       assign ifb.w_reg = w_reg;       assign ifc.w_reg = w_reg;
  assign ifa.w_data = w_data;     assign ifb.w_data = w_data;     assign ifc.w_data = w_data;
  assign ifa.w_en = w_en;         assign ifb.w_en = w_en;         assign ifc.w_en = w_en;
  assign ifa.bank_sel = bank_sel; assign ifb.bank_sel = bank_sel; assign ifc.bank_sel = bank_sel;
  assign ifa.bank_sel_en = bank_sel_en;
  assign ifb.bank_sel_en = bank_sel_en;
  assign ifc.bank_sel_en = bank_sel_en;
  assign ifa.copy_start = copy_start;
  assign ifb.copy_start = copy_start;
  assign ifc.copy_start = copy_start;
  assign ifa.copy_src = copy_src; assign ifb.copy_src = copy_src; assign ifc.copy_src = copy_src;
  assign ifa.copy_dst = copy_dst; assign ifb.copy_dst = copy_dst; assign ifc.copy_dst = copy_dst;

  banked_register_file #(
    .DATA_WIDTH(8), .REGISTER_ID_WIDTH(2), .BANK_ID_WIDTH(1), .BYPASS(1'b1), .ZERO_REG(1'b0)
  ) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));

  banked_register_file #(
    .DATA_WIDTH(8), .REGISTER_ID_WIDTH(2), .BANK_ID_WIDTH(1), .BYPASS(1'b0), .ZERO_REG(1'b0)
  ) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  banked_register_file #(
    .DATA_WIDTH(8), .REGISTER_ID_WIDTH(2), .BANK_ID_WIDTH(1), .BYPASS(1'b1), .ZERO_REG(1'b1)
  ) dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [1:0] r, input logic [7:0] d);
    w_en = 1'b1; w_reg = r; w_data = d;
    step();
    w_en = 1'b0;
  endtask

  initial begin
    // Reset
    step();
    rst_n = 1'b1;
    reg1 = 2'd1; reg2 = 2'd2;
    #1;
    check("rst_active_bank", ifa.active_bank, 0);
    check("rst_busy", ifa.busy, 0);
    check("rst_copy_done", ifa.copy_done, 0);
    check("rst_read1", ifa.read1, 8'h00);

    // Basic writes and reads
    write_reg(2'd1, 8'h5A);
    write_reg(2'd2, 8'hC3);
    #1;
    check("basic_read1", ifa.read1, 8'h5A);
    check("basic_read2", ifa.read2, 8'hC3);
    check("basic_active_bank", ifa.active_bank, 0);
    check("basic_busy", ifa.busy, 0);

    // Bypass versus no bypass
    reg1 = 2'd3; w_en = 1'b1; w_reg = 2'd3; w_data = 8'h77;
    #1;
    check("bypass_a_same_cycle", ifa.read1, 8'h77);
    check("nobypass_b_same_cycle", ifb.read1, 8'h00);
    check("bypass_c_same_cycle", ifc.read1, 8'h77);
    step();
    w_en = 1'b0;
    #1;
    check("nobypass_b_next_cycle", ifb.read1, 8'h77);
    check("bypass_a_next_cycle", ifa.read1, 8'h77);

    // Zero register
    reg1 = 2'd0; w_en = 1'b1; w_reg = 2'd0; w_data = 8'hFF;
    #1;
    check("zero_c_same_cycle", ifc.read1, 8'h00);
    check("zero_a_bypass_r0", ifa.read1, 8'hFF);
    step();
    w_en = 1'b0;
    #1;
    check("zero_c_later", ifc.read1, 8'h00);
    check("zero_a_stored_r0", ifa.read1, 8'hFF);

    // Bank switch: same-cycle write lands in the old bank
    write_reg(2'd1, 8'h11);
    reg1 = 2'd1;
    bank_sel = 1'b1; bank_sel_en = 1'b1; w_en = 1'b1; w_reg = 2'd1; w_data = 8'h22;
    step();
    bank_sel_en = 1'b0; w_en = 1'b0;
    #1;
    check("switch_active_bank1", ifa.active_bank, 1);
    check("switch_bank1_r1", ifa.read1, 8'h00);
    bank_sel = 1'b0; bank_sel_en = 1'b1;
    step();
    bank_sel_en = 1'b0;
    #1;
    check("switch_active_bank0", ifa.active_bank, 0);
    check("switch_bank0_r1", ifa.read1, 8'h22);

    // Copy bank 0 -> bank 1 with bank 1 active
    for (int i = 0; i < 4; i++) write_reg(2'(i), 8'(i + 1));
    bank_sel = 1'b1; bank_sel_en = 1'b1;
    step();
    bank_sel_en = 1'b0;
    copy_start = 1'b1; copy_src = 1'b0; copy_dst = 1'b1;
    step();
    copy_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("copy_busy_c%0d", k), ifa.busy, 1);
      check($sformatf("copy_done_low_c%0d", k), ifa.copy_done, 0);
      if (k == 0) begin
        // Both must be ignored while busy
        bank_sel = 1'b0; bank_sel_en = 1'b1;
        copy_start = 1'b1; copy_src = 1'b1; copy_dst = 1'b0;
      end
      if (k == 2) begin
        w_en = 1'b1; w_reg = 2'd2; w_data = 8'hAA;
      end
      step();
      bank_sel_en = 1'b0; copy_start = 1'b0; w_en = 1'b0;
    end
    #1;
    check("copy_done_pulse", ifa.copy_done, 1);
    check("copy_busy_after", ifa.busy, 0);
    check("copy_bank_sel_ignored", ifa.active_bank, 1);
    copy_start = 1'b1; copy_src = 1'b1; copy_dst = 1'b0;
    step();
    copy_start = 1'b0;
    #1;
    check("copy_done_one_cycle", ifa.copy_done, 0);
    check("copy_start_in_done_ignored", ifa.busy, 0);
    reg1 = 2'd0; reg2 = 2'd1;
    #1;
    check("copy_a_r0", ifa.read1, 8'h01);
    check("copy_a_r1", ifa.read2, 8'h02);
    check("copy_c_r0_zero", ifc.read1, 8'h00);
    check("copy_c_r1", ifc.read2, 8'h02);
    reg1 = 2'd2; reg2 = 2'd3;
    #1;
    check("copy_a_r2_user_wins", ifa.read1, 8'hAA);
    check("copy_a_r3", ifa.read2, 8'h04);
    check("copy_c_r2_user_wins", ifc.read1, 8'hAA);

    // Reset during the second COPY cycle
    copy_start = 1'b1; copy_src = 1'b1; copy_dst = 1'b0;
    step();
    copy_start = 1'b0;
    step();
    #1;
    check("midcopy_busy_before_rst", ifa.busy, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    check("midcopy_busy", ifa.busy, 0);
    check("midcopy_active_bank", ifa.active_bank, 0);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("midcopy_no_done_%0d", k), ifa.copy_done, 0);
      step();
    end
    for (int b = 0; b < 2; b++) begin
      for (int r = 0; r < 4; r++) begin
        reg1 = 2'(r);
        #1;
        check($sformatf("midcopy_b%0d_r%0d", b, r), ifa.read1, 8'h00);
      end
      bank_sel = 1'b1; bank_sel_en = 1'b1;
      step();
      bank_sel_en = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/banked_register_file.md
Name: banked_register_file

Overview:
Parametrised successor to the single-bank CPU register file: 2**BANK_ID_WIDTH banks of 2**REGISTER_ID_WIDTH registers, two combinational read ports and one write port on the active bank. Adds optional write-to-read bypass and an optional hardwired-zero register 0. Adds a multi-cycle bank-copy sequencer for context save/restore. Sits between the decode stage (read ids) and writeback (write port); the control unit drives bank switch and copy.

Parameters:
DATA_WIDTH, 8, register width in bits
REGISTER_ID_WIDTH, 2, register id width; DEPTH = 2**REGISTER_ID_WIDTH registers per bank
BANK_ID_WIDTH, 1, bank id width; NUM_BANKS = 2**BANK_ID_WIDTH (BANK_ID_WIDTH >= 1)
BYPASS, 1, 1 = a same-cycle write to the active bank is forwarded to matching read ports
ZERO_REG, 0, 1 = register 0 of every bank reads 0 and ignores all writes, including copy

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
reg1  input  REGISTER_ID_WIDTH  read port 1 id (active bank)
reg2  input  REGISTER_ID_WIDTH  read port 2 id (active bank)
read1  output  DATA_WIDTH  read port 1 data, combinational
read2  output  DATA_WIDTH  read port 2 data, combinational
w_reg  input  REGISTER_ID_WIDTH  write id (active bank)
w_data  input  DATA_WIDTH  write data
w_en  input  1  write enable
bank_sel  input  BANK_ID_WIDTH  new active bank
bank_sel_en  input  1  load bank_sel into the active-bank pointer
copy_start  input  1  start a bank copy (single-cycle request)
copy_src  input  BANK_ID_WIDTH  copy source bank, sampled on copy_start
copy_dst  input  BANK_ID_WIDTH  copy destination bank, sampled on copy_start
active_bank  output  BANK_ID_WIDTH  current active-bank pointer (registered)
busy  output  1  copy in progress
copy_done  output  1  one-cycle pulse when a copy completes

Behaviour:
- Reset (rst_n low at a clk edge): all registers in all banks = 0; active_bank = 0; busy = 0; copy_done = 0; FSM = IDLE. Reset mid-copy aborts it: no copy_done pulse, destination left partially copied and then cleared by reset.
- Reads: readN = active_bank[regN] combinationally. ZERO_REG=1 and regN==0 -> 0. BYPASS=1 and w_en and w_reg==regN (and not a zero-reg case) -> w_data. BYPASS=0 -> stored value (new value visible the cycle after the write).
- Write: w_en at the edge writes w_data to active_bank[w_reg]. Writes to reg 0 are dropped when ZERO_REG=1. Writes are accepted while busy.
- Bank switch: bank_sel_en at the edge loads active_bank <= bank_sel. Reads and writes in the same cycle use the old bank. bank_sel_en is ignored while busy.
- Copy FSM states: IDLE, COPY, DONE.
  - IDLE: on copy_start, latch src/dst, idx <= 0, go to COPY. busy goes 1 the next cycle.
  - COPY: each cycle dst[idx] <= src[idx] (pre-edge value), idx increments. After idx == DEPTH-1 is written, go to DONE. COPY lasts exactly DEPTH cycles.
  - DONE: copy_done = 1 and busy = 0 for one cycle, then IDLE. A copy_start in DONE is ignored.
- copy_start is ignored while busy or in DONE.
- copy_src == copy_dst runs the full sequence with no data change.
- Collision: a user write and a copy write to the same dst register in the same cycle -> the user write wins. A user write to src[idx] in the same cycle is not seen by the copy; the old value is copied.
- Arithmetic: idx is REGISTER_ID_WIDTH wide and never wraps past DEPTH-1 in COPY. No width extension on data.

Test Plan:
- Reset/basic: rst_n low 1 cycle, then write r1=0x5A, r2=0xC3 in bank 0; read reg1=1, reg2=2 -> read1=0x5A, read2=0xC3; active_bank=0, busy=0.
- Bypass: BYPASS=1, w_en with w_reg=3, w_data=0x77 while reg1=3 -> read1=0x77 in the same cycle. With BYPASS=0 -> old value (0x00), then 0x77 the next cycle.
- Zero reg: ZERO_REG=1, write r0=0xFF -> read r0=0x00 in the same cycle and later; copy leaves r0=0x00.
- Bank switch: bank 0 r1=0x11; bank_sel=1 with bank_sel_en and w_en (r1=0x22) in the same cycle -> bank0 r1=0x22; after the switch, r1 in bank 1 reads 0x00; switching back reads 0x22.
- Copy: bank0 = {0x01,0x02,0x03,0x04}; copy_start src=0, dst=1 -> busy high exactly 4 cycles, copy_done pulses 1 cycle, bank1 = {0x01,0x02,0x03,0x04}. bank_sel_en and a second copy_start during busy are ignored. A user write dst r2=0xAA in the cycle idx=2 -> bank1 r2=0xAA.
- Reset mid-copy: rst_n low during the 2nd COPY cycle -> busy=0, copy_done never pulses, all registers 0, active_bank=0.
